sw_pe_array_ctrl: RTL and testbench
===================================

// Module: sw_pe_array_ctrl
// PURPOSE
//  Parametrised Smith-Waterman systolic array with its own controller. Holds PE_NUM query (s)
//  chars, streams target (t) tokens through all PEs and hands per-pass boundary v/f back to the
//  Data Processor. Supports multi-pass queries, partial last segments, output back-pressure and
//  saturating scores. Sits between the Data Processor and top-level control.
// PARAMETERS
//  PE_NUM   64  number of PEs (query chars per pass), >=2
//  SCORE_W  12  unsigned score width (v, e, f, result)
//  MATCH_W   4  width of i_match
//  LEN_W    $clog2(PE_NUM+1)  width of i_s_len
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          async reset, active low
//  i_match        in   MATCH_W    match bonus
//  i_mismatch     in   SCORE_W    mismatch penalty (magnitude)
//  i_alpha        in   SCORE_W    gap-open penalty (magnitude)
//  i_beta         in   SCORE_W    gap-extend penalty (magnitude)
//  i_start        in   1          start a query (ignored while o_busy)
//  o_busy         out  1          high from accepted i_start until o_valid
//  o_init         out  1          1-cycle pulse at start of every pass
//  o_result       out  SCORE_W    best local score, valid with o_valid
//  o_valid        out  1          1-cycle pulse, query finished
//  i_s_valid/o_s_ready  in/out 1  s-segment handshake
//  i_s            in   2*PE_NUM   segment; PE k char = i_s[2*(PE_NUM-k)-1 -: 2]
//  i_s_len        in   LEN_W      chars in segment, 1..PE_NUM
//  i_s_last       in   1          segment is the last of the query
//  i_t_valid/o_t_ready  in/out 1  t-token handshake
//  i_t, i_v, i_f  in   2,SCORE_W,SCORE_W  token char, boundary H, boundary F
//  i_t_last       in   1          last token of this pass
//  o_t_valid/i_out_ready out/in 1 output-token handshake
//  o_t, o_v, o_f, o_t_last out 2,SCORE_W,SCORE_W,1  token leaving PE PE_NUM-1
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; PE regs, valid pipe and max cleared. Reset mid-pass aborts it.
//  FSM: IDLE -(i_start)-> LOAD (o_init=1 on entry, PE regs cleared) -(s handshake)-> RUN
//   -(i_t_last accepted)-> DRAIN -(last token out, seg not last)-> LOAD; -(seg last)-> DONE -> IDLE.
//  o_s_ready=1 only in LOAD; o_t_ready=1 only in RUN and not stalled. o_valid/o_result in DONE.
//  PE k stores s_k; PEs k>=i_s_len are bypass: forward token/v/f unchanged with 1-cycle delay.
//  Per-stage valid bit travels with each token; latency i_t accept -> o_t_valid = PE_NUM cycles
//   when unstalled, independent of i_s_len.
//  Stall: o_t_valid & !i_out_ready freezes every PE stage, valid pipe and max; no loss/duplication.
//  PE k, token j (regs Hl=H(k,j-1), E, Hd=H(k-1,j-1), all 0 at pass start):
//   sub = (s_k==t_j)? +i_match : -i_mismatch
//   E(k,j)=max(Hl-alpha, E-beta); F(k,j)=max(v_in-alpha, f_in-beta)
//   H(k,j)=max(0, Hd+sub, E(k,j), F(k,j)); forwards t_j, H(k,j), F(k,j).
//  Arithmetic in SCORE_W+2 bits; subtractions floor at 0, results saturate at 2^SCORE_W-1.
//  Max: running max over H of every active PE with a valid token; cleared in IDLE->LOAD of
//   first pass only, kept across passes. o_result = max at DONE.
//  DRAIN: no new tokens accepted; ends when o_t_last handshakes.
//  i_t_valid while not RUN: ignored. i_start while busy: ignored.
//  Zero tokens in a pass is illegal (i_t_last must accompany a valid token).
// TESTING
//  1 PE_NUM=4, s=ACGT last, t=ACGT, match2 mm1 a3 b1, i_v=i_f=0 -> o_result=8, o_t at +4 cycles.
//  2 s_len=2 "AC", t="AC" -> o_result=4, o_t latency still 4, o_v of last token = 4.
//  3 8-char query in two passes, o_v/o_f of pass1 fed back -> o_result matches golden, o_init x2.
//  4 i_out_ready low 3 cycles mid-stream -> o_t_ready=0 during stall, token sequence exact.
//  5 rst_n low during RUN -> all outputs 0, IDLE; following query gives correct fresh result.
//  6 SCORE_W=6, match 7, 16 identical chars -> o_result=63 (saturated), no wrap.

Source files
------------

// File: rtl/sw_pe_array_ctrl.sv
// Smith-Waterman systolic PE array with pass controller.
// Holds up to PE_NUM query characters per pass, streams target tokens through
// a chain of PEs and returns the boundary H/F of the last active PE so the
// Data Processor can feed them into the next pass of a longer query.
module sw_pe_array_ctrl #(
  parameter int PE_NUM  = 64,
  parameter int SCORE_W = 12,
  parameter int MATCH_W = 4,
  parameter int LEN_W   = $clog2(PE_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MATCH_W-1:0]    i_match,
  input  logic [SCORE_W-1:0]    i_mismatch,
  input  logic [SCORE_W-1:0]    i_alpha,
  input  logic [SCORE_W-1:0]    i_beta,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_init,
  output logic [SCORE_W-1:0]    o_result,
  output logic                  o_valid,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [2*PE_NUM-1:0]   i_s,
  input  logic [LEN_W-1:0]      i_s_len,
  input  logic                  i_s_last,
  input  logic                  i_t_valid,
  output logic                  o_t_ready,
  input  logic [1:0]            i_t,
  input  logic [SCORE_W-1:0]    i_v,
  input  logic [SCORE_W-1:0]    i_f,
  input  logic                  i_t_last,
  output logic                  o_t_valid,
  input  logic                  i_out_ready,
  output logic [1:0]            o_t,
  output logic [SCORE_W-1:0]    o_v,
  output logic [SCORE_W-1:0]    o_f,
  output logic                  o_t_last
);

  // Two guard bits so sums cannot wrap before saturation.
  localparam int AW = SCORE_W + 2;
  localparam logic [SCORE_W-1:0] SMAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;
  logic   seg_last_reg;
  logic   init_reg;

  logic stall, adv, in_fire, out_fire, s_fire;
  logic enter_load, first_load;

  // Per-stage outputs exposed so the next stage can read them.
  logic [1:0]         t_pipe    [PE_NUM];
  logic [SCORE_W-1:0] v_pipe    [PE_NUM];
  logic [SCORE_W-1:0] f_pipe    [PE_NUM];
  logic               vld_pipe  [PE_NUM];
  logic               last_pipe [PE_NUM];
  logic [SCORE_W-1:0] max_arr   [PE_NUM];
  logic [SCORE_W-1:0] best;

  function automatic logic [AW-1:0] sub_floor(input logic [SCORE_W-1:0] a,
                                              input logic [SCORE_W-1:0] b);
    return (a > b) ? (AW'(a) - AW'(b)) : '0;
  endfunction

  function automatic logic [AW-1:0] max2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [SCORE_W-1:0] sat(input logic [AW-1:0] x);
    return (x > AW'(SMAX)) ? SMAX : x[SCORE_W-1:0];
  endfunction

  assign o_t_valid = vld_pipe[PE_NUM-1];
  assign o_t       = t_pipe[PE_NUM-1];
  assign o_v       = v_pipe[PE_NUM-1];
  assign o_f       = f_pipe[PE_NUM-1];
  assign o_t_last  = last_pipe[PE_NUM-1];
  assign o_init    = init_reg;

  // A held output token freezes the whole array, so nothing is lost or repeated.
  assign stall    = o_t_valid & ~i_out_ready;
  assign adv      = ~stall;
  assign in_fire  = i_t_valid & o_t_ready;
  assign out_fire = o_t_valid & i_out_ready;
  assign s_fire   = i_s_valid & o_s_ready;

  assign enter_load = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
  assign first_load = (state_reg == ST_IDLE) && (state_next == ST_LOAD);

  // Controller state, pass-start pulse and last-segment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      seg_last_reg <= 1'b0;
      init_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      init_reg  <= enter_load;
      if (s_fire) seg_last_reg <= i_s_last;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_next = state_reg;
    o_busy     = 1'b1;
    o_s_ready  = 1'b0;
    o_t_ready  = 1'b0;
    o_valid    = 1'b0;
    o_result   = '0;
    case (state_reg)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_s_ready = 1'b1;
        if (i_s_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        o_t_ready = ~stall;
        if (i_t_valid && !stall && i_t_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_fire && o_t_last) state_next = seg_last_reg ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        o_valid    = 1'b1;
        o_result   = best;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Best score over all PEs; each PE keeps its own running maximum.
  always_comb begin
    best = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (max_arr[i] > best) best = max_arr[i];
    end
  end

  for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_pe
    localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);

    logic [1:0]         t_in;
    logic [SCORE_W-1:0] v_in, f_in;
    logic               vld_in, last_in;

    logic [1:0]         s_char_reg;
    logic               act_reg;
    logic [SCORE_W-1:0] hl_reg, e_reg, hd_reg, max_reg;
    logic [1:0]         t_reg;
    logic [SCORE_W-1:0] v_reg, f_reg;
    logic               vld_reg, last_reg;

    logic [AW-1:0]      diag;
    logic [SCORE_W-1:0] e_next, f_next, h_next;

    if (gi == 0) begin : g_src
      assign t_in    = i_t;
      assign v_in    = i_v;
      assign f_in    = i_f;
      assign vld_in  = in_fire;
      assign last_in = i_t_last;
    end else begin : g_chain
      assign t_in    = t_pipe[gi-1];
      assign v_in    = v_pipe[gi-1];
      assign f_in    = f_pipe[gi-1];
      assign vld_in  = vld_pipe[gi-1];
      assign last_in = last_pipe[gi-1];
    end

    assign t_pipe[gi]    = t_reg;
    assign v_pipe[gi]    = v_reg;
    assign f_pipe[gi]    = f_reg;
    assign vld_pipe[gi]  = vld_reg;
    assign last_pipe[gi] = last_reg;
    assign max_arr[gi]   = max_reg;

    // Affine-gap cell update for the token arriving at this PE.
    always_comb begin
      diag   = (s_char_reg == t_in) ? (AW'(hd_reg) + AW'(i_match))
                                    : sub_floor(hd_reg, i_mismatch);
      e_next = sat(max2(sub_floor(hl_reg, i_alpha), sub_floor(e_reg, i_beta)));
      f_next = sat(max2(sub_floor(v_in, i_alpha), sub_floor(f_in, i_beta)));
      h_next = sat(max2(diag, max2(AW'(e_next), AW'(f_next))));
    end

    // Stage registers: cleared per pass, loaded with the segment, advanced per token.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_char_reg <= '0;
        act_reg    <= 1'b0;
        hl_reg     <= '0;
        e_reg      <= '0;
        hd_reg     <= '0;
        max_reg    <= '0;
        t_reg      <= '0;
        v_reg      <= '0;
        f_reg      <= '0;
        vld_reg    <= 1'b0;
        last_reg   <= 1'b0;
      end else if (enter_load) begin
        hl_reg   <= '0;
        e_reg    <= '0;
        hd_reg   <= '0;
        t_reg    <= '0;
        v_reg    <= '0;
        f_reg    <= '0;
        vld_reg  <= 1'b0;
        last_reg <= 1'b0;
        // The best score survives across passes of the same query.
        if (first_load) max_reg <= '0;
      end else if (s_fire) begin
        s_char_reg <= i_s[2*(PE_NUM-gi)-1 -: 2];
        act_reg    <= (IDX < i_s_len);
      end else if (adv) begin
        vld_reg <= vld_in;
        if (vld_in) begin
          t_reg    <= t_in;
          last_reg <= last_in;
          if (act_reg) begin
            v_reg  <= h_next;
            f_reg  <= f_next;
            hl_reg <= h_next;
            e_reg  <= e_next;
            hd_reg <= v_in;
            if (h_next > max_reg) max_reg <= h_next;
          end else begin
            // Unused PE in a short segment: pass the boundary through untouched.
            v_reg <= v_in;
            f_reg <= f_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_array_ctrl.sv
// Self-checking bench for sw_pe_array_ctrl: directed table, stall, reset and
// randomized queries compared against a full dynamic-programming grid model.
module tb_sw_pe_array_ctrl;

  localparam int P    = 4;
  localparam int SW   = 6;
  localparam int MW   = 4;
  localparam int LW   = $clog2(P + 1);
  localparam int SMAX = (1 << SW) - 1;
  localparam int MAXL = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [MW-1:0] i_match = '0;
  logic [SW-1:0] i_mismatch = '0, i_alpha = '0, i_beta = '0;
  logic          i_start = 1'b0;
  logic          o_busy, o_init, o_valid;
  logic [SW-1:0] o_result;
  logic          i_s_valid = 1'b0, o_s_ready;
  logic [2*P-1:0] i_s = '0;
  logic [LW-1:0] i_s_len = '0;
  logic          i_s_last = 1'b0;
  logic          i_t_valid = 1'b0, o_t_ready;
  logic [1:0]    i_t = '0;
  logic [SW-1:0] i_v = '0, i_f = '0;
  logic          i_t_last = 1'b0;
  logic          o_t_valid, i_out_ready = 1'b1;
  logic [1:0]    o_t;
  logic [SW-1:0] o_v, o_f;
  logic          o_t_last;

  always #5 clk = ~clk;

  sw_pe_array_ctrl #(.PE_NUM(P), .SCORE_W(SW), .MATCH_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .i_match(i_match), .i_mismatch(i_mismatch),
    .i_alpha(i_alpha), .i_beta(i_beta), .i_start(i_start), .o_busy(o_busy),
    .o_init(o_init), .o_result(o_result), .o_valid(o_valid),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s(i_s), .i_s_len(i_s_len),
    .i_s_last(i_s_last), .i_t_valid(i_t_valid), .o_t_ready(o_t_ready),
    .i_t(i_t), .i_v(i_v), .i_f(i_f), .i_t_last(i_t_last),
    .o_t_valid(o_t_valid), .i_out_ready(i_out_ready), .o_t(o_t), .o_v(o_v),
    .o_f(o_f), .o_t_last(o_t_last)
  );

  int n_checks = 0;
  int n_errors = 0;
  int init_cnt = 0;

  always @(negedge clk) if (o_init) init_cnt++;

  // Query/target chars (A=0 C=1 G=2 T=3), scoring parameters, boundary rows.
  int qc [MAXL];
  int tc [MAXL];
  int cur_v [MAXL], cur_f [MAXL], exp_v [MAXL], exp_f [MAXL];
  int m_max;
  int mp_m, mp_mm, mp_a, mp_b;
  int last_v_seen;

  typedef struct packed {
    logic [31:0] q;     // char i at bits [2i+1:2i]
    logic [31:0] t;
    logic [7:0]  qlen;
    logic [7:0]  tlen;
    logic [7:0]  m, mm, a, b;
    logic [7:0]  exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic int fl0(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic set_params(input int m, input int mm, input int a, input int b);
    mp_m = m; mp_mm = mm; mp_a = a; mp_b = b;
    i_match = MW'(m); i_mismatch = SW'(mm); i_alpha = SW'(a); i_beta = SW'(b);
  endtask

  // Full grid for one pass: rows = query chars of the segment, columns = tokens.
  task automatic model_pass(input int qoff, input int len, input int tlen);
    int h [P][MAXL];
    int e [P][MAXL];
    int f [P][MAXL];
    int vup, fup, hd, hl, ep, d;
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < tlen; j++) begin
        vup = (k == 0) ? cur_v[j] : h[k-1][j];
        fup = (k == 0) ? cur_f[j] : f[k-1][j];
        hd  = (j == 0) ? 0 : ((k == 0) ? cur_v[j-1] : h[k-1][j-1]);
        hl  = (j == 0) ? 0 : h[k][j-1];
        ep  = (j == 0) ? 0 : e[k][j-1];
        e[k][j] = imax(fl0(hl - mp_a), fl0(ep - mp_b));
        f[k][j] = imax(fl0(vup - mp_a), fl0(fup - mp_b));
        d = (qc[qoff+k] == tc[j]) ? hd + mp_m : fl0(hd - mp_mm);
        h[k][j] = imax(d, imax(e[k][j], f[k][j]));
        if (h[k][j] > SMAX) h[k][j] = SMAX;
        m_max = imax(m_max, h[k][j]);
      end
    end
    for (int j = 0; j < tlen; j++) begin
      exp_v[j] = h[len-1][j];
      exp_f[j] = f[len-1][j];
    end
  endtask

  // mode 0: always ready; 1: random gaps and back-pressure; 2: 3-cycle stall mid-stream.
  task automatic run_pass(input int p, input int qlen, input int tlen, input int mode,
                          input bit last, input string tag);
    int len, it, sent, recvd, in_it, out_it, stall_left, stall_seen;
    bit stall_done, fin, fout;
    logic [2*P-1:0] sv;
    len = qlen - p * P;
    if (len > P) len = P;
    model_pass(p * P, len, tlen);
    it = 0;
    while (!o_s_ready && it < 50) begin @(negedge clk); it++; end
    if (!o_s_ready) begin fail_now({tag, ":s_ready_wait"}); return; end
    sv = '0;
    for (int k = 0; k < len; k++) sv[2*(P-k)-1 -: 2] = 2'(qc[p*P+k]);
    i_s = sv; i_s_len = LW'(len); i_s_last = last; i_s_valid = 1'b1;
    @(negedge clk);
    i_s_valid = 1'b0;
    sent = 0; recvd = 0; it = 0; in_it = -1; out_it = -1;
    stall_left = 0; stall_seen = 0; stall_done = 0;
    while (recvd < tlen && it < 400) begin
      if (mode == 2 && !stall_done && recvd == 1 && o_t_valid) begin
        stall_left = 3; stall_done = 1;
      end
      if (mode == 1) i_out_ready = ($urandom_range(3) != 0);
      else i_out_ready = (stall_left == 0);
      i_t_valid = (sent < tlen) && (mode != 1 || $urandom_range(3) != 0);
      if (sent < tlen) begin
        i_t = 2'(tc[sent]);
        i_v = SW'(cur_v[sent]);
        i_f = SW'(cur_f[sent]);
        i_t_last = (sent == tlen - 1);
      end
      #1;
      fin  = i_t_valid && o_t_ready;
      fout = o_t_valid && i_out_ready;
      if (o_t_valid && !i_out_ready) begin
        stall_seen++;
        chk({tag, ":t_ready_in_stall"}, int'(o_t_ready), 0);
      end
      if (fout) begin
        chk({tag, ":o_t"}, int'(o_t), tc[recvd]);
        chk({tag, ":o_v"}, int'(o_v), exp_v[recvd]);
        chk({tag, ":o_f"}, int'(o_f), exp_f[recvd]);
        chk({tag, ":o_t_last"}, int'(o_t_last), (recvd == tlen - 1) ? 1 : 0);
        $display("tok %s pass%0d #%0d t=%0d v=%0d f=%0d", tag, p, recvd, o_t, o_v, o_f);
        if (out_it < 0) out_it = it;
        last_v_seen = int'(o_v);
        recvd++;
      end
      if (fin) begin
        if (in_it < 0) in_it = it;
        sent++;
      end
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      it++;
    end
    i_t_valid = 1'b0;
    i_out_ready = 1'b1;
    if (recvd < tlen) fail_now({tag, ":token_drain"});
    else if (mode != 1) chk({tag, ":latency"}, out_it - in_it, P);
    if (mode == 2) chk({tag, ":stall_cycles"}, stall_seen, 3);
    for (int j = 0; j < tlen; j++) begin
      cur_v[j] = exp_v[j];
      cur_f[j] = exp_f[j];
    end
  endtask

  task automatic run_query(input int qlen, input int tlen, input int mode,
                           input int exp_res, input string tag);
    int npass, init0, it;
    npass = (qlen + P - 1) / P;
    for (int j = 0; j < MAXL; j++) begin cur_v[j] = 0; cur_f[j] = 0; end
    m_max = 0;
    init0 = init_cnt;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk({tag, ":busy"}, int'(o_busy), 1);
    for (int p = 0; p < npass; p++) run_pass(p, qlen, tlen, mode, p == npass - 1, tag);
    it = 0;
    while (!o_valid && it < 50) begin @(negedge clk); it++; end
    if (!o_valid) fail_now({tag, ":o_valid_wait"});
    else begin
      $display("query %s qlen=%0d tlen=%0d result=%0d model=%0d", tag, qlen, tlen, o_result, m_max);
      chk({tag, ":result_model"}, int'(o_result), m_max);
      if (exp_res >= 0) chk({tag, ":result_const"}, int'(o_result), exp_res);
    end
    @(negedge clk);
    chk({tag, ":valid_pulse"}, int'(o_valid), 0);
    chk({tag, ":idle_busy"}, int'(o_busy), 0);
    chk({tag, ":init_pulses"}, init_cnt - init0, npass);
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < MAXL; k++) begin
      qc[k] = int'(v.q[2*k +: 2]);
      tc[k] = int'(v.t[2*k +: 2]);
    end
    set_params(int'(v.m), int'(v.mm), int'(v.a), int'(v.b));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ":busy"}, int'(o_busy), 0);
    chk({tag, ":init"}, int'(o_init), 0);
    chk({tag, ":valid"}, int'(o_valid), 0);
    chk({tag, ":result"}, int'(o_result), 0);
    chk({tag, ":s_ready"}, int'(o_s_ready), 0);
    chk({tag, ":t_ready"}, int'(o_t_ready), 0);
    chk({tag, ":t_valid"}, int'(o_t_valid), 0);
    chk({tag, ":o_v"}, int'(o_v), 0);
  endtask

  initial begin
    // q, t, qlen, tlen, match, mismatch, alpha, beta, expected result
    vecs[0] = '{32'h0000_00E4, 32'h0000_00E4, 8'd4,  8'd4,  8'd2, 8'd1, 8'd3, 8'd1, 8'd8};   // ACGT/ACGT
    vecs[1] = '{32'h0000_0004, 32'h0000_0004, 8'd2,  8'd2,  8'd2, 8'd1, 8'd3, 8'd1, 8'd4};   // AC/AC
    vecs[2] = '{32'h0000_E4E4, 32'h0000_E4E4, 8'd8,  8'd8,  8'd2, 8'd1, 8'd3, 8'd1, 8'd16};  // two passes
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 8'd16, 8'd16, 8'd7, 8'd1, 8'd3, 8'd1, 8'd63};  // saturation
    vecs[4] = '{32'h0000_00AA, 32'h0000_0055, 8'd4,  8'd4,  8'd2, 8'd1, 8'd3, 8'd1, 8'd0};   // GGGG/CCCC
    vecs[5] = '{32'h0000_0000, 32'h0000_00CF, 8'd1,  8'd4,  8'd2, 8'd1, 8'd3, 8'd1, 8'd2};   // A/TTAT

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load_vec(vecs[i]);
      run_query(int'(vecs[i].qlen), int'(vecs[i].tlen), 0, int'(vecs[i].exp_res),
                $sformatf("vec%0d", i));
      if (i == 1) chk("vec1:last_o_v", last_v_seen, 4);
    end

    // Back-pressure held for three cycles in the middle of the output stream.
    load_vec(vecs[0]);
    for (int k = 0; k < 4; k++) tc[4+k] = tc[k];
    run_query(4, 8, 2, 8, "stall");

    // Reset while tokens are in flight, then a fresh query.
    load_vec(vecs[0]);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_s = 8'b00_01_10_11; i_s_len = LW'(4); i_s_last = 1'b1; i_s_valid = 1'b1;
    @(negedge clk);
    i_s_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_t = 2'(k); i_v = '0; i_f = '0; i_t_last = 1'b0; i_t_valid = 1'b1;
      @(negedge clk);
    end
    i_t_valid = 1'b0;
    chk("midrun:busy_before_reset", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_query(4, 4, 0, 8, "after_reset");

    // Randomized queries under random gaps and back-pressure.
    for (int r = 0; r < 10; r++) begin
      int ql, tl;
      ql = $urandom_range(12, 1);
      tl = $urandom_range(10, 1);
      for (int k = 0; k < MAXL; k++) begin
        qc[k] = $urandom_range(3);
        tc[k] = $urandom_range(3);
      end
      set_params($urandom_range(7), $urandom_range(15), $urandom_range(15), $urandom_range(7));
      run_query(ql, tl, 1, -1, $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
